data_sram_responder: RTL and testbench

- Slave-side responder for the CPU's data SRAM interface. It sits at the other end of the data_sram_en/we/addr/wdata/rdata bus driven by mycpu_top.
- Provides a local word RAM plus a small block of memory-mapped configuration registers: LED, switch input, free-running timer, compare match interrupt, and scratch.
- Read data uses the same timing the CPU's MEM stage expects: it is returned on the cycle after the request.

---
 rtl/data_sram_responder.sv | 137 +++++++++++++
 tb/tb_data_sram_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data SRAM bus responder: local word RAM plus memory-mapped LED/switch/timer/IRQ/scratch registers.
// Read data is registered and returned on the cycle after the request.
module data_sram_responder #(
  parameter int unsigned RAM_AW    = 10,
  parameter logic [31:0] CONF_BASE = 32'hbfaf_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch,
  output logic        timer_irq
);

  localparam int unsigned RAM_WORDS = 1 << RAM_AW;

  // Register offsets in words (addr[15:2]).
  localparam logic [13:0] OFF_LED     = 14'h0000;
  localparam logic [13:0] OFF_SWITCH  = 14'h0001;
  localparam logic [13:0] OFF_TIMER   = 14'h0002;
  localparam logic [13:0] OFF_COMPARE = 14'h0003;
  localparam logic [13:0] OFF_IRQ     = 14'h0004;
  localparam logic [13:0] OFF_SCRATCH = 14'h0005;

  logic [31:0]       mem [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic [13:0]       reg_off;
  logic              conf_sel;
  logic              rd_req;
  logic              wr_req;
  logic              ram_we;
  logic [31:0]       wmask;
  logic [31:0]       rd_val;
  logic [31:0]       merged;
  logic              unused_addr_lsbs;

  logic [31:0] rdata_q,   rdata_d;
  logic [15:0] led_q,     led_d;
  logic [31:0] timer_q,   timer_d;
  logic [31:0] compare_q, compare_d;
  logic        irq_q,     irq_d;
  logic [31:0] scratch_q, scratch_d;
  logic [7:0]  sw_meta_q;
  logic [7:0]  sw_sync_q;

  assign ram_idx          = data_sram_addr[RAM_AW+1:2];
  assign reg_off          = data_sram_addr[15:2];
  assign conf_sel         = (data_sram_addr[31:16] == CONF_BASE[31:16]);
  assign rd_req           = data_sram_en && (data_sram_we == 4'b0000);
  assign wr_req           = data_sram_en && (data_sram_we != 4'b0000);
  assign ram_we           = wr_req && !conf_sel && !reset;
  assign unused_addr_lsbs = ^data_sram_addr[1:0];
  assign wmask            = {{8{data_sram_we[3]}}, {8{data_sram_we[2]}},
                             {8{data_sram_we[1]}}, {8{data_sram_we[0]}}};

  // RAM contents are deliberately not reset; requests during reset are dropped.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_sram_we[b]) mem[ram_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (conf_sel) begin
      case (reg_off)
        OFF_LED:     rd_val = {16'h0000, led_q};
        OFF_SWITCH:  rd_val = {24'h000000, sw_sync_q};
        OFF_TIMER:   rd_val = timer_q;
        OFF_COMPARE: rd_val = compare_q;
        OFF_IRQ:     rd_val = {31'h0, irq_q};
        OFF_SCRATCH: rd_val = scratch_q;
        default:     rd_val = '0;
      endcase
    end else begin
      rd_val = mem[ram_idx];
    end
  end

  // The register read value doubles as the old value for the byte-lane merge.
  assign merged = (rd_val & ~wmask) | (data_sram_wdata & wmask);

  always_comb begin
    rdata_d   = rdata_q;
    led_d     = led_q;
    timer_d   = timer_q + 32'd1;
    compare_d = compare_q;
    irq_d     = irq_q;
    scratch_d = scratch_q;
    if (rd_req) rdata_d = rd_val;
    if (wr_req && conf_sel) begin
      case (reg_off)
        OFF_LED:     led_d     = merged[15:0];
        OFF_TIMER:   timer_d   = merged;
        OFF_COMPARE: compare_d = merged;
        OFF_IRQ:     if (data_sram_we[0] && data_sram_wdata[0]) irq_d = 1'b0;
        OFF_SCRATCH: scratch_d = merged;
        default:     ;
      endcase
    end
    // Evaluated after the clear so a coincident match keeps the flag set.
    if (timer_q == compare_q) irq_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q   <= '0;
      led_q     <= '0;
      timer_q   <= '0;
      compare_q <= '1;
      irq_q     <= 1'b0;
      scratch_q <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      timer_q   <= timer_d;
      compare_q <= compare_d;
      irq_q     <= irq_d;
      scratch_q <= scratch_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign timer_irq       = irq_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: directed scenarios then randomized traffic
// checked against a transaction-level memory/register model.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [7:0]  sw;
  logic        irq;

  always #5 clk = ~clk;

  data_sram_responder #(
    .RAM_AW(10),
    .CONF_BASE(32'hbfaf_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_sram_en(en),
    .data_sram_we(we),
    .data_sram_addr(addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .led(led),
    .switch(sw),
    .timer_irq(irq)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          chk;
    logic [31:0] v;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_mem [int];
  logic [15:0] m_led;
  logic [31:0] m_timer, m_cmp, m_scr, m_rd;
  logic        m_irq;
  bit          m_rd_known;
  logic [7:0]  m_s1, m_s2;

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] nv,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nv[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_led = 16'h0; m_timer = 32'h0; m_cmp = 32'hffff_ffff; m_irq = 1'b0; m_scr = 32'h0;
    m_s1 = 8'h0; m_s2 = 8'h0; m_rd = 32'h0; m_rd_known = 1'b1;
  endtask

  // One bus clock edge of the reference: reads see pre-edge state, then updates apply.
  task automatic model_step();
    int          idx;
    logic [15:0] off;
    bit          conf, hit, twr;
    exp_t        e;
    logic [31:0] cur;
    if (reset) begin
      model_reset();
      return;
    end
    idx  = int'((addr >> 2) % 1024);
    conf = (addr[31:16] == 16'hbfaf);
    off  = addr[15:0] & 16'hfffc;
    hit  = (m_timer == m_cmp);
    twr  = 1'b0;
    if (en && we == 4'h0) begin
      e.chk = 1'b1;
      e.v   = 32'h0;
      if (conf) begin
        case (off)
          16'h0000: e.v = {16'h0, m_led};
          16'h0004: e.v = {24'h0, m_s2};
          16'h0008: e.v = m_timer;
          16'h000c: e.v = m_cmp;
          16'h0010: e.v = {31'h0, m_irq};
          16'h0014: e.v = m_scr;
          default:  e.v = 32'h0;
        endcase
      end else if (m_mem.exists(idx)) e.v = m_mem[idx];
      else e.chk = 1'b0;
      exp_q.push_back(e);
      m_rd = e.v;
      m_rd_known = e.chk;
    end
    if (en && we != 4'h0) begin
      if (conf) begin
        case (off)
          16'h0000: begin cur = lane_merge({16'h0, m_led}, wdata, we); m_led = cur[15:0]; end
          16'h0008: begin m_timer = lane_merge(m_timer, wdata, we); twr = 1'b1; end
          16'h000c: m_cmp = lane_merge(m_cmp, wdata, we);
          16'h0010: if (we[0] && wdata[0]) m_irq = 1'b0;
          16'h0014: m_scr = lane_merge(m_scr, wdata, we);
          default:  ;
        endcase
      end else if (we == 4'hf) m_mem[idx] = wdata;
      else if (m_mem.exists(idx)) m_mem[idx] = lane_merge(m_mem[idx], wdata, we);
    end
    if (!twr) m_timer = m_timer + 32'd1;
    if (hit) m_irq = 1'b1;
    m_s2 = m_s1;
    m_s1 = sw;
  endtask

  always @(posedge clk) model_step();

  // Monitor: read responses appear one cycle after the request; otherwise rdata must hold.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) check("rdata", rdata, e.v);
    end else if (m_rd_known) begin
      check("rdata_hold", rdata, m_rd);
    end
    check("led", {16'h0, led}, {16'h0, m_led});
    check("timer_irq", {31'h0, irq}, {31'h0, m_irq});
  end

  task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    en = e; we = w; addr = a; wdata = d;
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  w;
    int          k;
    reset = 1'b1; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0; sw = 8'h0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // RAM byte-lane write
    cyc(1'b1, 4'hf, 32'h1c00_0010, 32'h1122_3344);
    cyc(1'b1, 4'h2, 32'h1c00_0010, 32'h0000_aa00);
    cyc(1'b1, 4'h0, 32'h1c00_0010, 32'h0);
    idle();
    #1 check("t1_ram_bytes", rdata, 32'h1122_aa44);

    // LED, read-only SWITCH, unmapped offset
    cyc(1'b1, 4'hf, 32'hbfaf_0000, 32'hdead_beef);
    cyc(1'b1, 4'h0, 32'hbfaf_0000, 32'h0);
    idle();
    #1 check("t2_led", {16'h0, led}, 32'h0000_beef);
    check("t2_led_rd", rdata, 32'h0000_beef);
    cyc(1'b1, 4'hf, 32'hbfaf_0004, 32'hffff_ffff);
    cyc(1'b1, 4'h0, 32'hbfaf_0020, 32'h0);
    idle();
    #1 check("t2_unmapped", rdata, 32'h0);
    cyc(1'b1, 4'h0, 32'hbfaf_0004, 32'h0);
    idle();
    #1 check("t2_switch_ro", rdata, 32'h0);

    // Timer / compare / W1C
    cyc(1'b1, 4'hf, 32'hbfaf_0008, 32'd10);
    cyc(1'b1, 4'hf, 32'hbfaf_000c, 32'd15);
    cyc(1'b1, 4'h0, 32'hbfaf_0008, 32'h0);
    idle();
    #1 check("t3_timer", rdata, 32'd11);
    check("t3_irq_low", {31'h0, irq}, 32'h0);
    repeat (5) idle();
    #1 check("t3_irq_set", {31'h0, irq}, 32'h1);
    cyc(1'b1, 4'hf, 32'hbfaf_0010, 32'h0);
    idle();
    #1 check("t3_w0_keeps", {31'h0, irq}, 32'h1);
    cyc(1'b1, 4'hf, 32'hbfaf_0010, 32'h1);
    idle();
    #1 check("t3_w1c", {31'h0, irq}, 32'h0);

    // Timer write priority and wrap
    cyc(1'b1, 4'hf, 32'hbfaf_0008, 32'hffff_fffe);
    idle();
    idle();
    cyc(1'b1, 4'h0, 32'hbfaf_0008, 32'h0);
    idle();
    #1 check("t4_wrap", rdata, 32'h0);

    // Switch synchronizer latency
    idle();
    sw = 8'ha5;
    cyc(1'b1, 4'h0, 32'hbfaf_0004, 32'h0);
    cyc(1'b1, 4'h0, 32'hbfaf_0004, 32'h0);
    #1 check("t5_sw_old", rdata, 32'h0);
    idle();
    #1 check("t5_sw_new", rdata, 32'h0000_00a5);

    // Async reset between a read request and its edge
    cyc(1'b1, 4'h0, 32'h1c00_0010, 32'h0);
    #2 reset = 1'b1;
    model_reset();
    #1 check("t6_rst_rdata", rdata, 32'h0);
    check("t6_rst_led", {16'h0, led}, 32'h0);
    @(negedge clk);
    en = 1'b0;
    reset = 1'b0;
    cyc(1'b1, 4'h0, 32'hbfaf_000c, 32'h0);
    cyc(1'b1, 4'h0, 32'h1c00_0010, 32'h0);
    #1 check("t6_compare", rdata, 32'hffff_ffff);
    idle();
    #1 check("t6_ram_kept", rdata, 32'h1122_aa44);

    // Randomized traffic over aliased RAM words and the register block
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'hf, 32'h1c00_0000 + 32'(i * 4), $urandom);
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      d = $urandom;
      if (k < 5) begin
        a = $urandom;
        a[11:2] = 10'($urandom_range(0, 15));
        a[1:0] = 2'b00;
        if (a[31:16] == 16'hbfaf) a[31:16] = 16'h1c00;
      end else begin
        a = 32'hbfaf_0000 | (32'($urandom_range(0, 8)) << 2);
        if (a[15:0] == 16'h000c && $urandom_range(0, 1) == 1) d = m_timer + 32'($urandom_range(2, 8));
      end
      if ($urandom_range(0, 9) == 0) sw = 8'($urandom);
      cyc($urandom_range(0, 9) != 0, w, a, d);
    end
    repeat (3) idle();
    #1 check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
